// File: rtl/ball_engine.sv
// Ball motion engine: tracks the ball over the paddle in IDLE, moves it once per frame
// in MOVE with wall/paddle/brick reflections, and holds it in MISS for a fixed number of frames.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | ball parked on the paddle, follows paddle_x, waits for launch
// S_MOVE | ball moves by step on every frame_tick
// S_MISS | ball frozen at the bottom, down-counts MISS_FRAMES frame ticks
module ball_engine #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int POS_W       = 10,
    parameter int BALL_SIZE   = 8,
    parameter int PADDLE_W    = 64,
    parameter int PADDLE_Y    = 440,
    parameter int SPEED_W     = 3,
    parameter int MISS_FRAMES = 60
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               launch,
    input  logic [POS_W-1:0]   paddle_x,
    input  logic [SPEED_W-1:0] speed,
    input  logic               brick_hit_x,
    input  logic               brick_hit_y,
    output logic [POS_W-1:0]   ball_x,
    output logic [POS_W-1:0]   ball_y,
    output logic               dir_x,
    output logic               dir_y,
    output logic [1:0]         state,
    output logic               bounce,
    output logic               miss
);

    localparam int XW    = POS_W + 1;
    localparam int CNT_W = $clog2(MISS_FRAMES + 1);

    localparam logic [XW-1:0]    X_MAX     = XW'(H_RES - BALL_SIZE);
    localparam logic [XW-1:0]    Y_PAD     = XW'(PADDLE_Y - BALL_SIZE);
    localparam logic [XW-1:0]    Y_MAX     = XW'(V_RES - BALL_SIZE);
    localparam logic [XW-1:0]    HALF_PAD  = XW'(PADDLE_W / 2);
    localparam logic [XW-1:0]    HALF_BALL = XW'(BALL_SIZE / 2);
    localparam logic [XW-1:0]    BS        = XW'(BALL_SIZE);
    localparam logic [XW-1:0]    PW        = XW'(PADDLE_W);
    localparam logic [POS_W-1:0] X_MAX_P   = POS_W'(H_RES - BALL_SIZE);
    localparam logic [POS_W-1:0] Y_PAD_P   = POS_W'(PADDLE_Y - BALL_SIZE);
    localparam logic [POS_W-1:0] Y_MAX_P   = POS_W'(V_RES - BALL_SIZE);
    localparam logic [POS_W-1:0] X_RST_P   = POS_W'((H_RES - BALL_SIZE) / 2);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(MISS_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_MISS = 2'd2
    } state_t;

    state_t             st_q, st_d;
    logic [POS_W-1:0]   x_q, x_d, y_q, y_d;
    logic               dx_q, dx_d, dy_q, dy_d;
    logic               flag_x_q, flag_x_d, flag_y_q, flag_y_d;
    logic               bounce_d, miss_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [XW-1:0] step, x_ext, y_ext, pad_ext, pad_end;
    logic [XW-1:0] idle_sum, idle_x, x_plus, y_plus;
    logic          eff_dx, eff_dy, paddle_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q     <= S_IDLE;
            x_q      <= X_RST_P;
            y_q      <= Y_PAD_P;
            dx_q     <= 1'b1;
            dy_q     <= 1'b0;
            flag_x_q <= 1'b0;
            flag_y_q <= 1'b0;
            bounce   <= 1'b0;
            miss     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            st_q     <= st_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            flag_x_q <= flag_x_d;
            flag_y_q <= flag_y_d;
            bounce   <= bounce_d;
            miss     <= miss_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        st_d     = st_q;
        x_d      = x_q;
        y_d      = y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        flag_x_d = flag_x_q | brick_hit_x;
        flag_y_d = flag_y_q | brick_hit_y;
        bounce_d = 1'b0;
        miss_d   = 1'b0;
        cnt_d    = cnt_q;

        step     = (speed == '0) ? XW'(1) : {{(XW-SPEED_W){1'b0}}, speed};
        x_ext    = {1'b0, x_q};
        y_ext    = {1'b0, y_q};
        pad_ext  = {1'b0, paddle_x};
        pad_end  = pad_ext + PW;
        x_plus   = x_ext + step;
        y_plus   = y_ext + step;
        eff_dx   = dx_q;
        eff_dy   = dy_q;

        // Centre the ball over the paddle, clamped to the visible field.
        idle_sum = pad_ext + HALF_PAD;
        idle_x   = (idle_sum < HALF_BALL) ? '0 : idle_sum - HALF_BALL;
        if (idle_x > X_MAX) idle_x = X_MAX;

        paddle_hit = (y_ext <= Y_PAD) && (y_plus >= Y_PAD) &&
                     (x_ext + BS > pad_ext) && (x_ext < pad_end);

        case (st_q)
            S_IDLE: begin
                x_d  = idle_x[POS_W-1:0];
                y_d  = Y_PAD_P;
                dx_d = 1'b1;
                dy_d = 1'b0;
                if (launch) st_d = S_MOVE;
            end
            S_MOVE: begin
                if (frame_tick) begin
                    // Pending brick hits flip direction before this frame's motion.
                    eff_dx   = dx_q ^ flag_x_d;
                    eff_dy   = dy_q ^ flag_y_d;
                    flag_x_d = 1'b0;
                    flag_y_d = 1'b0;
                    dx_d     = eff_dx;
                    dy_d     = eff_dy;

                    if (eff_dx) begin
                        if (x_plus >= X_MAX) begin
                            x_d      = X_MAX_P;
                            dx_d     = 1'b0;
                            bounce_d = 1'b1;
                        end else begin
                            x_d = x_plus[POS_W-1:0];
                        end
                    end else begin
                        if (x_ext <= step) begin
                            x_d      = '0;
                            dx_d     = 1'b1;
                            bounce_d = 1'b1;
                        end else begin
                            x_d = x_q - step[POS_W-1:0];
                        end
                    end

                    if (!eff_dy) begin
                        if (y_ext <= step) begin
                            y_d      = '0;
                            dy_d     = 1'b1;
                            bounce_d = 1'b1;
                        end else begin
                            y_d = y_q - step[POS_W-1:0];
                        end
                    end else if (paddle_hit) begin
                        y_d      = Y_PAD_P;
                        dy_d     = 1'b0;
                        bounce_d = 1'b1;
                    end else if (y_plus >= Y_MAX) begin
                        y_d    = Y_MAX_P;
                        miss_d = 1'b1;
                        st_d   = S_MISS;
                        cnt_d  = CNT_LOAD;
                    end else begin
                        y_d = y_plus[POS_W-1:0];
                    end
                end
            end
            S_MISS: begin
                if (frame_tick) begin
                    if (cnt_q == '0) st_d = S_IDLE;
                    else             cnt_d = cnt_q - 1'b1;
                end
            end
            default: st_d = S_IDLE;
        endcase
    end

    assign ball_x = x_q;
    assign ball_y = y_q;
    assign dir_x  = dx_q;
    assign dir_y  = dy_q;
    assign state  = st_q;

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine: frame-tick stimulus pushes expected post-tick outputs
// into a queue; a monitor pops and compares on the cycle after each tick.
module tb_ball_engine;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst;
    logic       frame_tick, launch, brick_hit_x, brick_hit_y;
    logic [9:0] paddle_x;
    logic [2:0] speed;
    logic [9:0] ball_x, ball_y;
    logic       dir_x, dir_y, bounce, miss;
    logic [1:0] state;

    always #5 if (clk_en) clk = ~clk;

    ball_engine dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .launch      (launch),
        .paddle_x    (paddle_x),
        .speed       (speed),
        .brick_hit_x (brick_hit_x),
        .brick_hit_y (brick_hit_y),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .dir_x       (dir_x),
        .dir_y       (dir_y),
        .state       (state),
        .bounce      (bounce),
        .miss        (miss)
    );

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       dx;
        logic       dy;
        logic [1:0] st;
        logic       b;
        logic       m;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic tick_seen = 1'b0;

    function automatic exp_t mk(int x, int y, int dx, int dy, int st, int b, int m);
        exp_t e;
        e.x  = 10'(x);
        e.y  = 10'(y);
        e.dx = 1'(dx);
        e.dy = 1'(dy);
        e.st = 2'(st);
        e.b  = 1'(b);
        e.m  = 1'(m);
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input int x, input int y,
                             input int dx, input int dy, input int st);
        chk({name, ".ball_x"}, ball_x, x);
        chk({name, ".ball_y"}, ball_y, y);
        chk({name, ".dir_x"},  dir_x,  dx);
        chk({name, ".dir_y"},  dir_y,  dy);
        chk({name, ".state"},  state,  st);
    endtask

    // Monitor: frame_tick seen at a rising edge means the DUT presents a new result.
    always @(posedge clk) tick_seen <= frame_tick;

    always @(negedge clk) begin
        if (tick_seen) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: DUT update with no expected entry at %0t", $time);
            end else begin
                mon_e = q.pop_front();
                chk("tick.ball_x", ball_x, mon_e.x);
                chk("tick.ball_y", ball_y, mon_e.y);
                chk("tick.dir_x",  dir_x,  mon_e.dx);
                chk("tick.dir_y",  dir_y,  mon_e.dy);
                chk("tick.state",  state,  mon_e.st);
                chk("tick.bounce", bounce, mon_e.b);
                chk("tick.miss",   miss,   mon_e.m);
            end
        end else if (rst) begin
            chk("quiet.bounce", bounce, 0);
            chk("quiet.miss",   miss,   0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick(input exp_t e, input logic hx = 1'b0, input logic hy = 1'b0);
        @(negedge clk);
        frame_tick  = 1'b1;
        brick_hit_x = hx;
        brick_hit_y = hy;
        q.push_back(e);
        @(negedge clk);
        frame_tick  = 1'b0;
        brick_hit_x = 1'b0;
        brick_hit_y = 1'b0;
        @(negedge clk);
    endtask

    task automatic launch_pulse;
        @(negedge clk);
        launch = 1'b1;
        @(negedge clk);
        launch = 1'b0;
        chk("launch.state", state, 1);
    endtask

    task automatic brick_pulse(input logic hx, input logic hy);
        @(negedge clk);
        brick_hit_x = hx;
        brick_hit_y = hy;
        @(negedge clk);
        brick_hit_x = 1'b0;
        brick_hit_y = 1'b0;
    endtask

    task automatic summary;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        summary();
        $finish;
    end

    initial begin
        rst = 1'b1;
        frame_tick = 1'b0;
        launch = 1'b0;
        brick_hit_x = 1'b0;
        brick_hit_y = 1'b0;
        paddle_x = 10'd288;
        speed = 3'd4;

        // Asynchronous reset with no clock running.
        #2 rst = 1'b0;
        #2 check_out("reset", 316, 432, 1, 0, 0);
        chk("reset.bounce", bounce, 0);
        chk("reset.miss", miss, 0);
        clk_en = 1'b1;
        cyc(2);
        rst = 1'b1;
        cyc(3);
        check_out("idle288", 316, 432, 1, 0, 0);
        paddle_x = 10'd700;
        cyc(2);
        chk("idle_clamp.ball_x", ball_x, 632);
        paddle_x = 10'd288;
        cyc(2);
        chk("idle_back.ball_x", ball_x, 316);

        // Launch up-right, step 4; brick reversals; speed 0 means step 1.
        launch_pulse();
        tick(mk(320, 428, 1, 0, 1, 0, 0));
        tick(mk(324, 424, 1, 0, 1, 0, 0));
        tick(mk(328, 420, 1, 0, 1, 0, 0));
        brick_pulse(1'b0, 1'b1);
        check_out("pending", 328, 420, 1, 0, 1);
        tick(mk(332, 424, 1, 1, 1, 0, 0));
        tick(mk(328, 428, 0, 1, 1, 0, 0), 1'b1, 1'b0);
        speed = 3'd0;
        tick(mk(327, 429, 0, 1, 1, 0, 0));

        // Reset mid-move with the clock stopped.
        @(negedge clk);
        clk_en = 1'b0;
        rst = 1'b0;
        #20 check_out("rst_move", 316, 432, 1, 0, 0);
        chk("rst_move.bounce", bounce, 0);
        chk("rst_move.miss", miss, 0);
        rst = 1'b1;
        #3 clk_en = 1'b1;

        // Right wall, then long climb to the top wall at step 7.
        paddle_x = 10'd582;
        speed = 3'd4;
        cyc(3);
        check_out("idle582", 610, 432, 1, 0, 0);
        launch_pulse();
        tick(mk(614, 428, 1, 0, 1, 0, 0));
        tick(mk(618, 424, 1, 0, 1, 0, 0));
        tick(mk(622, 420, 1, 0, 1, 0, 0));
        tick(mk(626, 416, 1, 0, 1, 0, 0));
        tick(mk(630, 412, 1, 0, 1, 0, 0));
        tick(mk(632, 408, 0, 0, 1, 1, 0));
        speed = 3'd7;
        for (int k = 1; k <= 58; k++)
            tick(mk(632 - 7 * k, 408 - 7 * k, 0, 0, 1, 0, 0));
        tick(mk(219, 0, 0, 1, 1, 1, 0));

        // Descend past the paddle row far from the paddle, left wall, bottom miss.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        paddle_x = 10'd0;
        cyc(3);
        check_out("idle0", 28, 432, 1, 0, 0);
        launch_pulse();
        paddle_x = 10'd500;
        brick_pulse(1'b1, 1'b1);
        tick(mk(21, 439, 0, 1, 1, 0, 0));
        tick(mk(14, 446, 0, 1, 1, 0, 0));
        tick(mk(7, 453, 0, 1, 1, 0, 0));
        tick(mk(0, 460, 1, 1, 1, 1, 0));
        tick(mk(7, 467, 1, 1, 1, 0, 0));
        tick(mk(14, 472, 1, 1, 2, 0, 1));
        launch = 1'b1;
        for (int k = 1; k <= 59; k++)
            tick(mk(14, 472, 1, 1, 2, 0, 0));
        launch = 1'b0;
        tick(mk(14, 472, 1, 1, 0, 0, 0));
        cyc(1);
        check_out("after_miss", 528, 432, 1, 0, 0);

        // Paddle reflection overrides a pending vertical brick toggle.
        paddle_x = 10'd0;
        cyc(2);
        chk("idle0b.ball_x", ball_x, 28);
        launch_pulse();
        brick_pulse(1'b0, 1'b1);
        tick(mk(35, 432, 1, 0, 1, 1, 0));

        for (int i = 0; i < 20; i++) begin
            if (q.size() == 0) break;
            cyc(1);
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        cyc(2);
        summary();
        $finish;
    end

endmodule
